// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register file write port, with a zero-fill sequence after reset or init_req.
// Optional macro REGFILE_ZERO_HARDWIRE_EN: granted writes to address 0 are dropped (rf_op=0).
module regfile_write_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 5,
   parameter int DATA_W  = 32
) (
   input  logic                       clk,
   input  logic                       clr_n,
   input  logic                       init_req,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*ADDR_W-1:0]  wr_addr,
   input  logic [NUM_REQ*DATA_W-1:0]  wr_data,
   output logic [NUM_REQ-1:0]         gnt,
   output logic [ADDR_W-1:0]          rf_writereg,
   output logic                       rf_op,
   output logic [DATA_W-1:0]          rf_data_in,
   output logic                       init_busy
);

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam logic [PTR_W:0]    NUM_REQ_P = (PTR_W+1)'(NUM_REQ);
   localparam logic [ADDR_W-1:0] CNT_MAX   = {ADDR_W{1'b1}};

   typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

   state_t               r_state, w_state_nxt;
   logic [ADDR_W-1:0]    r_cnt, w_cnt_nxt;
   logic [PTR_W-1:0]     r_ptr, w_ptr_nxt;
   logic [NUM_REQ-1:0]   r_gnt, w_gnt_nxt;
   logic                 r_op, w_op_nxt;
   logic [ADDR_W-1:0]    r_addr, w_addr_nxt;
   logic [DATA_W-1:0]    r_data, w_data_nxt;
   logic                 r_busy, w_busy_nxt;

   logic [NUM_REQ-1:0]   w_elig;
   logic [2*NUM_REQ-1:0] w_rot;
   logic                 w_found;
   logic [PTR_W-1:0]     w_off, w_win, w_ptr_adv;
   logic [PTR_W:0]       w_sum, w_win_ext, w_adv_ext;
   logic [NUM_REQ-1:0]   w_onehot;
   logic [ADDR_W-1:0]    w_sel_addr;
   logic [DATA_W-1:0]    w_sel_data;
   logic                 w_grant_op;

   // Round-robin search: rotate eligible set so the pointer sits at bit 0, take the lowest set bit.
   always_comb begin
      w_elig     = req & ~r_gnt;
      w_rot      = {w_elig, w_elig} >> r_ptr;
      w_found    = 1'b0;
      w_off      = {PTR_W{1'b0}};
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_found = w_found | w_rot[k];
         w_off   = w_rot[k] ? PTR_W'(k) : w_off;
      end
      w_sum      = {1'b0, r_ptr} + {1'b0, w_off};
      w_win_ext  = (w_sum >= NUM_REQ_P) ? (w_sum - NUM_REQ_P) : w_sum;
      w_win      = w_win_ext[PTR_W-1:0];
      w_adv_ext  = {1'b0, w_win} + (PTR_W+1)'(1);
      w_ptr_adv  = (w_adv_ext >= NUM_REQ_P) ? {PTR_W{1'b0}} : w_adv_ext[PTR_W-1:0];
      w_onehot   = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;
      w_sel_addr = {ADDR_W{1'b0}};
      w_sel_data = {DATA_W{1'b0}};
      for (int k = 0; k < NUM_REQ; k++) begin
         w_sel_addr = (PTR_W'(k) == w_win) ? wr_addr[k*ADDR_W +: ADDR_W] : w_sel_addr;
         w_sel_data = (PTR_W'(k) == w_win) ? wr_data[k*DATA_W +: DATA_W] : w_sel_data;
      end
   end

`ifdef REGFILE_ZERO_HARDWIRE_EN
   assign w_grant_op = (w_sel_addr != {ADDR_W{1'b0}});
`else
   assign w_grant_op = 1'b1;
`endif

   // Next-state and next-output logic for the INIT/RUN sequencer.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_ptr_nxt   = r_ptr;
      w_gnt_nxt   = {NUM_REQ{1'b0}};
      w_op_nxt    = 1'b0;
      w_addr_nxt  = r_addr;
      w_data_nxt  = r_data;
      w_busy_nxt  = r_busy;
      case (r_state)
         S_INIT: begin
            w_op_nxt   = 1'b1;
            w_addr_nxt = r_cnt;
            w_data_nxt = {DATA_W{1'b0}};
            w_busy_nxt = 1'b1;
            if (r_cnt == CNT_MAX) begin
               w_cnt_nxt   = {ADDR_W{1'b0}};
               w_state_nxt = S_RUN;
            end else begin
               w_cnt_nxt   = r_cnt + ADDR_W'(1);
            end
         end
         S_RUN: begin
            w_busy_nxt = 1'b0;
            // init_req wins over any grant this edge; the request stays pending.
            if (init_req) begin
               w_state_nxt = S_INIT;
               w_cnt_nxt   = {ADDR_W{1'b0}};
               w_busy_nxt  = 1'b1;
            end else if (w_found) begin
               w_gnt_nxt  = w_onehot;
               w_op_nxt   = w_grant_op;
               w_addr_nxt = w_sel_addr;
               w_data_nxt = w_sel_data;
               w_ptr_nxt  = w_ptr_adv;
            end else begin
               w_gnt_nxt  = {NUM_REQ{1'b0}};
               w_op_nxt   = 1'b0;
            end
         end
         default: begin
            w_state_nxt = S_INIT;
            w_cnt_nxt   = {ADDR_W{1'b0}};
            w_busy_nxt  = 1'b1;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_state <= S_INIT;
         r_cnt   <= {ADDR_W{1'b0}};
         r_ptr   <= {PTR_W{1'b0}};
         r_gnt   <= {NUM_REQ{1'b0}};
         r_op    <= 1'b0;
         r_addr  <= {ADDR_W{1'b0}};
         r_data  <= {DATA_W{1'b0}};
         r_busy  <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ptr   <= w_ptr_nxt;
         r_gnt   <= w_gnt_nxt;
         r_op    <= w_op_nxt;
         r_addr  <= w_addr_nxt;
         r_data  <= w_data_nxt;
         r_busy  <= w_busy_nxt;
      end
   end

   assign gnt         = r_gnt;
   assign rf_op       = r_op;
   assign rf_writereg = r_addr;
   assign rf_data_in  = r_data;
   assign init_busy   = r_busy;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a negedge-sampled register file model.
module tb_regfile_write_arbiter;

   logic          clk = 1'b0;
   logic          clr_n;
   logic          init_req;
   logic [3:0]    req;
   logic [19:0]   wr_addr;
   logic [127:0]  wr_data;
   logic [3:0]    gnt;
   logic [4:0]    rf_writereg;
   logic          rf_op;
   logic [31:0]   rf_data_in;
   logic          init_busy;
   logic [31:0]   rf_mem [0:31];
   int            n_checks = 0;
   int            n_errors = 0;
   int            w;
   int            exp_order [8];

   regfile_write_arbiter dut (
      .clk(clk), .clr_n(clr_n), .init_req(init_req), .req(req),
      .wr_addr(wr_addr), .wr_data(wr_data), .gnt(gnt),
      .rf_writereg(rf_writereg), .rf_op(rf_op), .rf_data_in(rf_data_in),
      .init_busy(init_busy)
   );

   always #5 clk = ~clk;

   // Register file model: samples the write port on the falling edge.
   always @(negedge clk) begin
      if (rf_op) rf_mem[rf_writereg] <= rf_data_in;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
      wr_addr[i*5 +: 5]  = a;
      wr_data[i*32 +: 32] = d;
   endtask

   task automatic fill_check(input bit pulse_mid);
      for (int k = 0; k < 32; k++) begin
         @(negedge clk);
         chk("fill", {gnt, rf_op, init_busy, rf_writereg, rf_data_in},
             {4'b0000, 1'b1, 1'b1, 5'(k), 32'h0});
         init_req = (pulse_mid && k == 10);
      end
      init_req = 1'b0;
   endtask

   initial begin
      clr_n = 1'b0; init_req = 1'b0; req = 4'b0000; wr_addr = '0; wr_data = '0;
      repeat (2) @(negedge clk);
      chk("reset", {gnt, rf_op, init_busy, rf_writereg, rf_data_in},
          {4'b0000, 1'b0, 1'b1, 5'd0, 32'h0});
      clr_n = 1'b1;
      fill_check(1'b0);
      @(negedge clk);
      chk("init_done", {gnt, rf_op, init_busy}, {4'b0000, 1'b0, 1'b0});

      // single write to address 5
      set_req(0, 5'd5, 32'hDEADBEEF);
      req = 4'b0001;
      @(negedge clk);
      chk("single_gnt", {gnt, rf_op, rf_writereg, rf_data_in}, {4'b0001, 1'b1, 5'd5, 32'hDEADBEEF});
      req = 4'b0000;
      @(negedge clk);
      chk("single_idle", {gnt, rf_op, rf_writereg, rf_data_in}, {4'b0000, 1'b0, 5'd5, 32'hDEADBEEF});
      @(negedge clk); #1;
      chk("rf_read5", rf_mem[5], 32'hDEADBEEF);

      // all four requesting: pointer sits at 1 after the previous grant to 0
      for (int i = 0; i < 4; i++) set_req(i, 5'(8 + i), 32'hA0 + i);
      req = 4'b1111;
      exp_order = '{1, 2, 3, 0, 1, 2, 3, 0};
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         w = exp_order[c];
         chk("rr", {gnt, rf_op, rf_writereg, rf_data_in},
             {4'b0001 << w, 1'b1, 5'(8 + w), 32'hA0 + w});
      end
      req = 4'b0000;
      @(negedge clk);
      chk("rr_idle", {gnt, rf_op}, {4'b0000, 1'b0});

      // lone master holding req gets every other cycle
      set_req(0, 5'd3, 32'h1234);
      req = 4'b0001;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("alt", {gnt, rf_op}, (c % 2 == 0) ? {4'b0001, 1'b1} : {4'b0000, 1'b0});
      end
      req = 4'b0000;

      // init_req in RUN suppresses the grant; a second pulse mid-fill is ignored
      set_req(1, 5'd7, 32'h55);
      req = 4'b0010;
      init_req = 1'b1;
      @(negedge clk);
      chk("reinit", {gnt, rf_op, init_busy}, {4'b0000, 1'b0, 1'b1});
      init_req = 1'b0;
      fill_check(1'b1);
      @(negedge clk);
      chk("post_init_gnt", {gnt, rf_op, init_busy, rf_writereg, rf_data_in},
          {4'b0010, 1'b1, 1'b0, 5'd7, 32'h55});
      req = 4'b0000;

      // three grants (pointer now 2) then asynchronous reset
      for (int i = 0; i < 4; i++) set_req(i, 5'(16 + i), 32'hC0 + i);
      req = 4'b1111;
      exp_order = '{2, 3, 0, 0, 0, 0, 0, 0};
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         w = exp_order[c];
         chk("pre_rst", {gnt, rf_writereg, rf_data_in}, {4'b0001 << w, 5'(16 + w), 32'hC0 + w});
      end
      #2 clr_n = 1'b0;
      #1;
      chk("async_rst", {gnt, rf_op, init_busy, rf_writereg, rf_data_in},
          {4'b0000, 1'b0, 1'b1, 5'd0, 32'h0});
      req = 4'b0000;
      @(negedge clk);
      clr_n = 1'b1;
      fill_check(1'b0);
      @(negedge clk);
      chk("init_done2", {gnt, rf_op, init_busy}, {4'b0000, 1'b0, 1'b0});

      // write to register 0
      set_req(0, 5'd0, 32'h1);
      req = 4'b0001;
      @(negedge clk);
`ifdef REGFILE_ZERO_HARDWIRE_EN
      chk("zero_gnt", {gnt, rf_op}, {4'b0001, 1'b0});
`else
      chk("zero_gnt", {gnt, rf_op}, {4'b0001, 1'b1});
`endif
      req = 4'b0000;
      @(negedge clk); #1;
`ifdef REGFILE_ZERO_HARDWIRE_EN
      chk("rf_read0", rf_mem[0], 32'h0);
`else
      chk("rf_read0", rf_mem[0], 32'h1);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
